piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter with a load handshake, a stall control, a runtime bit-order select and frame tracking.
- It supersedes the fixed 8-bit PISO for datapaths that need arbitrary widths, MSB- or LSB-first order, back-to-back frames and a per-frame "last bit" marker.
- It sits between a parallel producer (register file, FIFO) and a serial link or bit-bang interface.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range is WIDTH >= 2.
- IDLE_LEVEL, 1'b0: value driven on ser_out when no frame is active.
- CNT_W, $clog2(WIDTH): bit-counter width; derived only, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-high (asserted = 1).
- par_in  in  WIDTH  parallel word to serialise.
- load_valid  in  1  producer offers par_in.
- load_ready  out  1  block can accept par_in this cycle.
- lsb_first  in  1  bit order for the offered word: 1 = LSB first, 0 = MSB first; sampled only on load.
- shift_en  in  1  advance one bit this cycle; 0 = stall.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out carries frame data.
- last  out  1  ser_out is the final bit of the frame.
- busy  out  1  frame in progress.

Behaviour:
- Storage: shreg[WIDTH-1:0], cnt[CNT_W-1:0], dir (1 bit), state ∈ {IDLE, SHIFT}.
- Reset (rst_n = 1, asynchronous): state = IDLE, shreg = 0, cnt = 0, dir = 0.
  - While reset is asserted, outputs are: ser_out = IDLE_LEVEL, ser_valid = 0, last = 0, busy = 0, load_ready = 0.
  - Reset mid-frame discards the frame immediately, with no partial-bit completion.
- Outputs are combinational from state only; no input-to-output paths except load_ready's dependence on shift_en and rst_n:
  - busy = ser_valid = (state == SHIFT).
  - ser_out = IDLE_LEVEL in IDLE; otherwise shreg[0] if dir = 1, else shreg[WIDTH-1].
  - last = (state == SHIFT) && (cnt == WIDTH-1).
  - load_ready = !rst_n && (state == IDLE || (last && shift_en)).
- Load: a word is accepted on a rising edge with load_valid && load_ready. On acceptance: shreg <= par_in, dir <= lsb_first, cnt <= 0, state <= SHIFT.
  - The first bit appears on ser_out in the cycle after acceptance (latency 1).
  - load_valid without load_ready has no effect. The producer must hold par_in stable until accepted.
- SHIFT with shift_en = 0: everything holds, including ser_out and last. There is no timeout.
- SHIFT with shift_en = 1 and cnt < WIDTH-1:
  - Shift toward the output end: right if dir = 1, left if dir = 0.
  - Zero-fill the vacated end.
  - cnt <= cnt + 1.
- SHIFT with shift_en = 1 and cnt == WIDTH-1 (final bit consumed):
  - If load_valid = 1: back-to-back reload per the load rule. There is no idle gap, and ser_valid stays 1.
  - Otherwise: state <= IDLE, and cnt and shreg are cleared.
- One frame is exactly WIDTH bits with shift_en high. Stall cycles do not count.
- lsb_first and par_in changes mid-frame have no effect on the current frame.
- In IDLE, shift_en is ignored.
- cnt never exceeds WIDTH-1. For non-power-of-two WIDTH, the compare is exact and unused codes are unreachable.
- Simultaneous rising edge of rst_n with load_valid: reset wins and nothing is loaded.

Test Plan:
- WIDTH = 8, reset: with rst_n = 1, check ser_out = 0, ser_valid = busy = last = load_ready = 0. Release reset -> load_ready = 1.
- MSB-first: load 8'hA5 with lsb_first = 0, shift_en held 1 -> ser_out sequence 1,0,1,0,0,1,0,1. last is high only on the 8th bit. Returns to IDLE, and ser_out = IDLE_LEVEL on cycle 9.
- LSB-first with stalls: load 8'hC3 with lsb_first = 1; drop shift_en for 3 cycles after bit 2 -> sequence 1,1,0,0,0,0,1,1. ser_out and last hold during the stall. Total frame time is 11 cycles.
- Back-to-back: keep load_valid = 1 with 8'hF0 then 8'h0F, shift_en = 1 -> 16 contiguous valid bits with ser_valid never dropping. load_ready pulses on bit 8 only.
- Reset mid-frame: assert rst_n asynchronously (between clock edges) at bit 4 of 8'hFF -> outputs go to reset values before the next clock edge. The next load after release starts a fresh 8-bit frame.
- Parameter sweep: WIDTH = 5 with IDLE_LEVEL = 1, load 5'b10011, MSB-first -> sequence 1,0,0,1,1, then ser_out idles at 1. A mid-frame change of lsb_first is ignored.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in / serial-out shifter.
//
// A word is accepted with a valid/ready handshake, then shifted out one bit
// per cycle where shift_en is high, MSB- or LSB-first as selected at load time.
// A new word can be accepted in the same cycle the final bit is consumed, so
// frames can run back-to-back with no idle gap.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active HIGH (asserted = 1)
//   par_in      parallel word to serialise
//   load_valid  producer offers par_in
//   load_ready  word can be accepted this cycle
//   lsb_first   bit order for the offered word (1 = LSB first), sampled on load
//   shift_en    advance one bit this cycle; 0 = stall
//   ser_out     current serial bit (IDLE_LEVEL when no frame is active)
//   ser_valid   ser_out carries frame data
//   last        ser_out is the final bit of the frame
//   busy        frame in progress
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0,
    localparam int  CNT_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt,   cnt_nxt;
    logic             dir,   dir_nxt;
    logic             accept;

    // Outputs come from registered state only; load_ready additionally looks
    // at shift_en so a new word can slip in as the final bit is consumed.
    assign busy       = (state == SHIFT);
    assign ser_valid  = busy;
    assign last       = busy && (cnt == CNT_LAST);
    assign ser_out    = busy ? (dir ? shreg[0] : shreg[WIDTH-1]) : IDLE_LEVEL;
    assign load_ready = !rst_n && (!busy || (last && shift_en));
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        if (accept) begin
            // Covers both a load from IDLE and a back-to-back reload.
            state_nxt = SHIFT;
            shreg_nxt = par_in;
            cnt_nxt   = '0;
            dir_nxt   = lsb_first;
        end else if (busy && shift_en) begin
            if (last) begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end else begin
                // Move the next bit toward the output end, zero-filling behind.
                shreg_nxt = dir ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a WIDTH=8/IDLE_LEVEL=0 and a WIDTH=5/IDLE_LEVEL=1
// instance share one stimulus bus. The reference model holds each frame as a
// queue of bits still to be sent; its head is the expected ser_out.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [7:0] par = '0;
    logic       lv  = 1'b0;
    logic       lsb = 1'b0;
    logic       se  = 1'b0;
    logic [1:0] so, sv, lst, bsy, lr;

    piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .rst_n(rst), .par_in(par), .load_valid(lv), .load_ready(lr[0]),
        .lsb_first(lsb), .shift_en(se), .ser_out(so[0]), .ser_valid(sv[0]),
        .last(lst[0]), .busy(bsy[0])
    );

    piso_serializer #(.WIDTH(5), .IDLE_LEVEL(1'b1)) dut5 (
        .clk(clk), .rst_n(rst), .par_in(par[4:0]), .load_valid(lv), .load_ready(lr[1]),
        .lsb_first(lsb), .shift_en(se), .ser_out(so[1]), .ser_valid(sv[1]),
        .last(lst[1]), .busy(bsy[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic bit idl(input int i);
        return (i == 1);
    endfunction

    // ---------------- reference model ----------------
    bit mq[2][$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq[0].delete();
            mq[1].delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit rdy;
                rdy = (mq[i].size() == 0) || (mq[i].size() == 1 && se);
                if (lv && rdy) begin
                    mq[i].delete();
                    for (int b = 0; b < wid(i); b++)
                        mq[i].push_back(lsb ? par[b] : par[wid(i)-1-b]);
                end else if (mq[i].size() != 0 && se) begin
                    void'(mq[i].pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit eb, es, el, er;
            eb = (mq[i].size() != 0);
            es = eb ? mq[i][0] : idl(i);
            el = (mq[i].size() == 1);
            er = !rst && (!eb || (el && se));
            chk($sformatf("busy[%0d]", i),       32'(bsy[i]), 32'(eb));
            chk($sformatf("ser_valid[%0d]", i),  32'(sv[i]),  32'(eb));
            chk($sformatf("ser_out[%0d]", i),    32'(so[i]),  32'(es));
            chk($sformatf("last[%0d]", i),       32'(lst[i]), 32'(el));
            chk($sformatf("load_ready[%0d]", i), 32'(lr[i]),  32'(er));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        lv = 1'b0;
        se = 1'b1;
        k  = 0;
        while (bsy != 2'b00 && k < 50) begin
            tick();
            k++;
        end
        chk("wait_idle", 32'(bsy), 32'd0);
    endtask

    // Loads d, then collects the bits of instance inst as they are consumed.
    // shift_en is low for st_len cycles starting at cycle st_at. lsb_first and
    // par_in are changed right after the load to show they are ignored.
    task automatic run_frame(input int inst, input logic [7:0] d, input logic l,
                             input int st_at, input int st_len,
                             output logic [7:0] seq, output logic [7:0] lseq,
                             output int nbusy);
        int nb;
        nb = 0; seq = '0; lseq = '0; nbusy = 0;
        par = d; lsb = l; lv = 1'b1; se = 1'b1;
        tick();
        lv = 1'b0; lsb = ~l; par = ~d;
        for (int c = 0; c < 40 && nb < wid(inst); c++) begin
            se = !(c >= st_at && c < st_at + st_len);
            @(negedge clk);
            if (bsy[inst]) nbusy++;
            if (se) begin
                seq  = {seq[6:0], so[inst]};
                lseq = {lseq[6:0], lst[inst]};
                nb++;
            end
            tick();
        end
        se = 1'b1;
        @(negedge clk);
        if (bsy[inst]) nbusy++;
    endtask

    logic [7:0]  seq, ls;
    logic [15:0] seq16, lrv;
    int          nb, nsv;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst ser_out8",    32'(so[0]),  32'd0);
        chk("rst ser_out5",    32'(so[1]),  32'd1);
        chk("rst ser_valid",   32'(sv[0]),  32'd0);
        chk("rst busy",        32'(bsy[0]), 32'd0);
        chk("rst last",        32'(lst[0]), 32'd0);
        chk("rst load_ready",  32'(lr[0]),  32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst load_ready", 32'(lr[0]), 32'd1);
        tick();

        // MSB first, no stalls
        run_frame(0, 8'hA5, 1'b0, 99, 0, seq, ls, nb);
        chk("msb seq",   32'(seq), 32'hA5);
        chk("msb last",  32'(ls),  32'h01);
        chk("msb busy cycles", 32'(nb), 32'd8);
        chk("msb idle ser_out",   32'(so[0]), 32'd0);
        chk("msb idle ser_valid", 32'(sv[0]), 32'd0);
        tick();
        wait_idle();

        // LSB first with a 3-cycle stall after bit 2
        run_frame(0, 8'hC3, 1'b1, 2, 3, seq, ls, nb);
        chk("lsb seq",  32'(seq), 32'hC3);
        chk("lsb last", 32'(ls),  32'h01);
        chk("lsb busy cycles", 32'(nb), 32'd11);
        tick();
        wait_idle();

        // Back-to-back frames
        par = 8'hF0; lsb = 1'b0; lv = 1'b1; se = 1'b1;
        tick();
        par = 8'h0F;
        seq16 = '0; lrv = '0; nsv = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            seq16 = {seq16[14:0], so[0]};
            lrv   = {lrv[14:0], lr[0]};
            nsv  += int'(sv[0]);
            tick();
            if (k == 7) lv = 1'b0;
        end
        chk("b2b seq", 32'(seq16), 32'hF00F);
        chk("b2b ser_valid count", 32'(nsv), 32'd16);
        chk("b2b load_ready pulse", 32'(lrv[15:1]), 32'h0080);
        wait_idle();

        // Asynchronous reset mid-frame
        par = 8'hFF; lsb = 1'b0; lv = 1'b1; se = 1'b1;
        tick();
        lv = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst busy",       32'(bsy[0]), 32'd0);
        chk("async rst ser_valid",  32'(sv[0]),  32'd0);
        chk("async rst ser_out",    32'(so[0]),  32'd0);
        chk("async rst last",       32'(lst[0]), 32'd0);
        chk("async rst load_ready", 32'(lr[0]),  32'd0);
        tick();
        rst = 1'b0;
        run_frame(0, 8'h3C, 1'b0, 99, 0, seq, ls, nb);
        chk("after rst seq",  32'(seq), 32'h3C);
        chk("after rst busy cycles", 32'(nb), 32'd8);
        tick();
        wait_idle();

        // WIDTH=5, IDLE_LEVEL=1 instance
        run_frame(1, 8'h13, 1'b0, 99, 0, seq, ls, nb);
        chk("w5 seq",  32'(seq[4:0]), 32'h13);
        chk("w5 last", 32'(ls[4:0]),  32'h01);
        chk("w5 busy cycles", 32'(nb), 32'd5);
        chk("w5 idle ser_out", 32'(so[1]), 32'd1);
        tick();
        wait_idle();

        // Random traffic, with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            lv  = 1'($urandom_range(0, 1));
            par = 8'($urandom);
            lsb = 1'($urandom_range(0, 1));
            se  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
